bcd_digit_scanner: RTL
======================

// Module: bcd_digit_scanner
// PURPOSE
//   Upstream feeder for the BCD-to-seven-segment decoder.
//   Converts a binary value to DIGITS packed BCD digits using sequential double-dabble, one shift per clock.
//   Time-multiplexes those digits onto a single 4-bit bcd bus with an active-low one-hot digit select.
//   The decoder turns bcd into segments; digit_sel drives the display common lines.
// PARAMETERS
//   BIN_W    14     width of the binary input; must satisfy 2**BIN_W > 10**DIGITS - 1
//   DIGITS   4      number of display digits; range 1..8
//   SCAN_DIV 50000  clocks per digit slot; must be >= 1
// PORTS
//   clk        in   1         single clock; every register is rising-edge
//   rst_n      in   1         synchronous reset, active-low
//   load       in   1         request to convert bin_in; sampled only while busy=0
//   bin_in     in   BIN_W     unsigned binary value
//   busy       out  1         conversion in progress
//   overflow   out  1         last accepted value was >= 10**DIGITS
//   bcd        out  4         BCD digit of the current scan slot; feeds the decoder
//   digit_sel  out  DIGITS    active-low one-hot select of the current slot
// BEHAVIOUR
//   Reset: rst_n sampled low at a clock edge. All outputs and state are registered.
//     - State=IDLE, busy=0, overflow=0.
//     - All displayed digits=0, slot index=0, prescaler=0.
//     - bcd=4'h0, digit_sel=~1 (digit 0 active).
//     - Reset mid-conversion aborts it; the partial result is discarded.
//   FSM (IDLE -> SHIFT -> COMMIT -> IDLE):
//     - IDLE: load=1 at edge k captures bin_in and clears the BCD accumulator.
//       Goes to SHIFT; busy=1 from edge k.
//     - SHIFT: BIN_W cycles.
//       Each cycle, add 3 to every BCD nibble >= 5, then shift left 1, taking the binary MSB in.
//     - COMMIT: 1 cycle. Copies the accumulator into the display register, or all 9s if overflow.
//       busy=0 after edge k+BIN_W+1; new digits are visible from that edge.
//     - load while busy=0 is accepted; load while busy=1 is ignored, not queued.
//   Overflow:
//     - At capture, bin_in >= 10**DIGITS sets overflow=1; otherwise overflow is cleared.
//     - overflow holds until the next accepted load.
//   Scan:
//     - Runs independently of the FSM, never stalls.
//     - Prescaler counts 0..SCAN_DIV-1. On wrap, slot index advances; DIGITS-1 wraps to 0.
//     - Slot 0 is the least significant digit.
//     - bcd and digit_sel update on the same edge.
//     - Exactly one digit_sel bit is low, except in blanked slots.
//     - A display update mid-slot changes bcd on the next edge without disturbing the index or prescaler.
//   Widths:
//     - Accumulator is 4*DIGITS bits; adds are per-nibble with no carry between nibbles.
//     - Shift counter is clog2(BIN_W+1) bits.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     - Slots above the most significant nonzero committed digit drive digit_sel all ones.
//     - bcd is still the stored 0 in those slots.
//     - Slot 0 is never blanked, so a value of 0 shows "0".
//     - Overflow (all 9s) blanks nothing.
//   Not defined: every slot is always enabled.
// TESTING (DIGITS=4, BIN_W=14, SCAN_DIV=4)
//   - Reset: hold rst_n=0 for 1 edge -> bcd=0, digit_sel=4'b1110, busy=0, overflow=0.
//   - load 1234 -> busy=1 for exactly 15 cycles; then slots show 4,3,2,1.
//     Each slot lasts 4 clocks; digit_sel cycles 1110, 1101, 1011, 0111.
//   - load 10000 -> overflow=1, digits 9999; then load 42 -> overflow=0, digits 0042.
//   - load 5678, then load 1111 on the 3rd busy cycle -> result 5678; second load is dropped.
//   - rst_n=0 on the 7th SHIFT cycle -> busy=0, digits 0000; a following load 9 shows 0009.
//   - load 42 with LEADING_ZERO_BLANK_EN -> slots 2 and 3 drive digit_sel=4'b1111.
//     Without the macro -> those slots drive bcd=0 with their select low.

Source files
------------

// File: rtl/bcd_digit_scanner.sv
// -----------------------------------------------------------------------------
// bcd_digit_scanner
//   Upstream feeder for a BCD-to-seven-segment decoder. A binary value is
//   converted to DIGITS packed BCD digits by sequential double-dabble (one
//   shift per clock). The committed digits are then time-multiplexed onto a
//   single 4-bit bus with an active-low one-hot digit select.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous reset, active-low
//   load       in   1       convert bin_in; honoured only while busy=0
//   bin_in     in   BIN_W   unsigned binary value
//   busy       out  1       conversion in progress
//   overflow   out  1       last accepted value was >= 10**DIGITS
//   bcd        out  4       digit of the current scan slot
//   digit_sel  out  DIGITS  active-low one-hot select of the current slot
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, slots above the most significant
//   nonzero committed digit drive digit_sel all ones (slot 0 never blanks).
//   When undefined, every slot is always enabled.
// -----------------------------------------------------------------------------
module bcd_digit_scanner #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BIN_W-1:0]  bin_in,
  output logic              busy,
  output logic              overflow,
  output logic [3:0]        bcd,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int ACC_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [63:0]      LIMIT     = 64'(10 ** DIGITS);
  localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [ACC_W-1:0]    disp_q, disp_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic                upper_nz;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset is synchronous, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (load) state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == CNT_W'(BIN_W - 1)) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Double-dabble datapath
  // ---------------------------------------------------------------------------
  // Per-nibble "add 3 if >= 5"; nibbles never carry into each other.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d  = bin_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    disp_d = disp_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d = bin_in;
          acc_d = '0;
          cnt_d = '0;
          ovf_d = (64'(bin_in) >= LIMIT);
        end
      end
      S_SHIFT: begin
        acc_d = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_COMMIT: disp_d = ovf_q ? ALL_NINES : acc_q;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan: free-running prescaler and slot index. bcd/digit_sel are computed
  // from the next-cycle display and slot, so a commit is visible on the same
  // edge that writes the display register.
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    slot_d = slot_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d  = '0;
      slot_d = (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end

    bcd_d = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (SLOT_W'(i) == slot_d) bcd_d = disp_d[4*i +: 4];
    end

    sel_d = ~(DIGITS'(1) << slot_d);
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this slot and everything above it is zero; slot 0 always shows.
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (SLOT_W'(i) >= slot_d && disp_d[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
    if (slot_d != '0 && !upper_nz) sel_d = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      disp_q <= '0;
      pre_q  <= '0;
      slot_q <= '0;
      bcd_q  <= 4'h0;
      sel_q  <= ~DIGITS'(1);
    end else begin
      bin_q  <= bin_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      disp_q <= disp_d;
      pre_q  <= pre_d;
      slot_q <= slot_d;
      bcd_q  <= bcd_d;
      sel_q  <= sel_d;
    end
  end

  assign overflow  = ovf_q;
  assign bcd       = bcd_q;
  assign digit_sel = sel_q;

endmodule
